routex_xbar_sched: RTL and testbench
====================================

Name: routex_xbar_sched

Overview:
- Packet-granular crossbar scheduler for the routex 4-port router.
- Each input port presents a packet-head request: destination output plus length in 512-bit flits (8x64-bit words).
- Per output, the scheduler picks one requesting input round-robin and holds the grant until the packet's last flit has transferred.
- It drives the per-output source selects, D_BP to the inputs, and the Q_SOF/Q_EOF framing for the crossbar datapath.

Parameters:
- NUM_PORTS, 4, number of input ports and output ports.
- PORT_W, 2, select width (log2 NUM_PORTS).
- LEN_W, 16, packet-length field width, in flits.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- REQ_VALID  in  [NUM_PORTS-1:0]  input i has a packet head waiting.
- REQ_DST  in  [NUM_PORTS-1:0][PORT_W-1:0]  requested output for input i.
- REQ_LEN  in  [NUM_PORTS-1:0][LEN_W-1:0]  packet length in flits, header flit included.
- D_VALID  in  [NUM_PORTS-1:0]  flit valid on input i.
- Q_BP  in  [NUM_PORTS-1:0]  downstream backpressure per output.
- D_BP  out  [NUM_PORTS-1:0]  backpressure to input i.
- GRANT  out  [NUM_PORTS-1:0]  input i currently owns an output.
- SEL  out  [NUM_PORTS-1:0][PORT_W-1:0]  source input index for output o.
- SEL_VALID  out  [NUM_PORTS-1:0]  output o is allocated.
- Q_SOF  out  [NUM_PORTS-1:0]  first flit of the packet transfers on output o this cycle.
- Q_EOF  out  [NUM_PORTS-1:0]  last flit of the packet transfers on output o this cycle.

Behaviour:
- Reset (RST_N=0 at a posedge):
  - GRANT, SEL, SEL_VALID, remaining counters and first-flags clear to 0.
  - Every rr_ptr[o] resets to NUM_PORTS-1, so input 0 has first priority.
  - Combinational outputs during reset: Q_SOF=Q_EOF=0, D_BP=all 1.
  - Reset mid-packet abandons the packet immediately; no EOF is emitted.
- Per-output FSM, IDLE/BUSY.
- IDLE:
  - Candidates are inputs i with REQ_VALID[i] & REQ_DST[i]==o & !GRANT[i].
  - Winner is the first candidate searching rr_ptr[o]+1, rr_ptr[o]+2, ... modulo NUM_PORTS.
  - If a winner exists, at the next edge: BUSY, SEL[o]=winner, SEL_VALID[o]=1, GRANT[winner]=1, rem[o]=max(REQ_LEN[winner],1), first[o]=1.
  - Grant latency is 1 cycle from request.
- BUSY:
  - xfer[o] = D_VALID[SEL[o]] & !Q_BP[o].
  - On xfer: rem decrements and first clears.
  - On xfer with rem==1: at the next edge go to IDLE, SEL_VALID=0, GRANT[SEL]=0, rr_ptr[o]=SEL.
  - Minimum one idle cycle between consecutive packets on the same output.
- Combinational outputs:
  - Q_SOF[o] = xfer[o] & first[o].
  - Q_EOF[o] = xfer[o] & (rem[o]==1).
  - A 1-flit packet asserts SOF and EOF together.
  - D_BP[i] = !GRANT[i] | Q_BP[dst_of_i]. dst_of_i is the output whose SEL_VALID=1 and SEL==i; it is registered at grant.
- Request rules:
  - REQ_DST and REQ_LEN must be stable while REQ_VALID=1 and GRANT=0.
  - While GRANT[i]=1, REQ_VALID[i] is ignored.
  - An input is never granted two outputs, because GRANT[i] masks it from all arbiters.
- Simultaneous events:
  - Outputs arbitrate independently in the same cycle; distinct destinations are all granted together.
  - A release and a new request in the same cycle: the request is arbitrated in the following IDLE cycle.
  - D_VALID while Q_BP=1: no transfer, counters hold.
- Width: rem is LEN_W bits, saturating at 0; no wrap is possible, since the decrement only happens when rem>=1.

Test Plan:
1. Single packet, 3 flits, no stalls.
   - Stimulus: reset; at cycle 0 REQ_VALID[0]=1, REQ_DST[0]=2, REQ_LEN[0]=3; D_VALID[0]=1 throughout.
   - Required: at cycle 1 GRANT[0]=1, SEL[2]=0, SEL_VALID[2]=1, Q_SOF[2]=1; Q_EOF[2] at cycle 3; GRANT[0]=0 and SEL_VALID[2]=0 at cycle 4.
2. Round-robin contention.
   - Stimulus: all four inputs request output 1, REQ_LEN=2, continuous D_VALID.
   - Required: grants in order 0,1,2,3, each starting 3 cycles apart (2 flits + 1 idle); rr_ptr[1]=3 at the end.
   - Follow-up: re-request from inputs 3 and 0; input 0 wins.
3. Permutation.
   - Stimulus: input i -> output 3-i, REQ_LEN=4, all in the same cycle.
   - Required: all four GRANTs and SEL_VALIDs rise in the same cycle; SEL = {0,1,2,3} for outputs 3..0; four EOFs in the same cycle.
4. Stalls mid-packet.
   - Stimulus: 5-flit packet to output 0; Q_BP[0]=1 for 2 cycles at flit 3; then D_VALID=0 for 1 cycle at flit 4.
   - Required: D_BP high for the granted input during the BP cycles; rem holds through both stalls; EOF is 3 cycles later than unstalled.
5. Length 0 and length 1.
   - Stimulus: one request with REQ_LEN=0, another with REQ_LEN=1.
   - Required: each transfers exactly 1 flit with Q_SOF=Q_EOF=1 in the same cycle.
6. Reset mid-packet.
   - Stimulus: RST_N=0 for one edge at flit 2 of an 8-flit packet.
   - Required: the next cycle has GRANT=0, SEL_VALID=0, D_BP=all 1; no Q_EOF; the next request is granted with input-0-first priority.

Source files
------------

// File: rtl/routex_xbar_sched.sv
// routex_xbar_sched: packet-granular crossbar scheduler for the routex 4-port router.
// Each output arbitrates round-robin among requesting inputs and holds the grant until EOF.
module routex_xbar_sched #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 2,
   parameter int LEN_W     = 16
) (
   input  logic                             CLK,
   input  logic                             RST_N,
   input  logic [NUM_PORTS-1:0]             REQ_VALID,
   input  logic [NUM_PORTS-1:0][PORT_W-1:0] REQ_DST,
   input  logic [NUM_PORTS-1:0][LEN_W-1:0]  REQ_LEN,
   input  logic [NUM_PORTS-1:0]             D_VALID,
   input  logic [NUM_PORTS-1:0]             Q_BP,
   output logic [NUM_PORTS-1:0]             D_BP,
   output logic [NUM_PORTS-1:0]             GRANT,
   output logic [NUM_PORTS-1:0][PORT_W-1:0] SEL,
   output logic [NUM_PORTS-1:0]             SEL_VALID,
   output logic [NUM_PORTS-1:0]             Q_SOF,
   output logic [NUM_PORTS-1:0]             Q_EOF
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t                           state [NUM_PORTS];
   logic [NUM_PORTS-1:0][PORT_W-1:0] rr_ptr;
   logic [NUM_PORTS-1:0][LEN_W-1:0]  rem;
   logic [NUM_PORTS-1:0]             first;
   logic [NUM_PORTS-1:0][PORT_W-1:0] dst_of;

   logic [NUM_PORTS-1:0]             win_found;
   logic [NUM_PORTS-1:0][PORT_W-1:0] win_idx;
   logic [NUM_PORTS-1:0]             xfer;
   logic [NUM_PORTS-1:0]             last;

   function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base, input int k);
      return PORT_W'((int'(base) + k) % NUM_PORTS);
   endfunction

   // Search starts just after the last winner, so that input gets lowest priority next time.
   always_comb begin : arb
      logic [PORT_W-1:0] cand;
      cand = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         // NOTE: every combinational output gets a default first, so no path can infer a latch.
         win_found[o] = 1'b0;
         win_idx[o]   = '0;
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = wrap_add(rr_ptr[o], k);
            if (!win_found[o] && (state[o] == ST_IDLE) && REQ_VALID[cand] && !GRANT[cand] &&
                (REQ_DST[cand] == PORT_W'(o))) begin
               win_found[o] = 1'b1;
               win_idx[o]   = cand;
            end
         end
      end
   end

   // Framing and backpressure are forced quiet while reset is asserted, before the edge lands.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         SEL_VALID[o] = (state[o] == ST_BUSY);
         xfer[o]      = SEL_VALID[o] && D_VALID[SEL[o]] && !Q_BP[o];
         last[o]      = xfer[o] && (rem[o] == LEN_W'(1));
         Q_SOF[o]     = RST_N && xfer[o] && first[o];
         Q_EOF[o]     = RST_N && last[o];
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         D_BP[i] = !RST_N || !GRANT[i] || Q_BP[dst_of[i]];
      end
   end

   // NOTE: state uses non-blocking assignments only, so every output sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         // NOTE: these per-port arrays are plain flops, not RAM, so clearing them in reset is cheap and required.
         for (int o = 0; o < NUM_PORTS; o++) begin
            state[o]  <= ST_IDLE;
            SEL[o]    <= '0;
            rr_ptr[o] <= PORT_W'(NUM_PORTS - 1);
            rem[o]    <= '0;
            first[o]  <= 1'b0;
         end
         GRANT  <= '0;
         dst_of <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            case (state[o])
               ST_IDLE: begin
                  if (win_found[o]) begin
                     state[o]               <= ST_BUSY;
                     SEL[o]                 <= win_idx[o];
                     GRANT[win_idx[o]]      <= 1'b1;
                     dst_of[win_idx[o]]     <= PORT_W'(o);
                     rem[o]                 <= (REQ_LEN[win_idx[o]] == '0) ? LEN_W'(1)
                                                                          : REQ_LEN[win_idx[o]];
                     first[o]               <= 1'b1;
                  end
               end
               ST_BUSY: begin
                  if (xfer[o]) begin
                     first[o] <= 1'b0;
                     if (rem[o] != '0) rem[o] <= rem[o] - LEN_W'(1);
                     if (last[o]) begin
                        state[o]      <= ST_IDLE;
                        GRANT[SEL[o]] <= 1'b0;
                        rr_ptr[o]     <= SEL[o];
                     end
                  end
               end
               default: state[o] <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_routex_xbar_sched.sv
// Self-checking bench for routex_xbar_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a packet-level model.
module tb_routex_xbar_sched;

   localparam int N  = 4;
   localparam int PW = 2;
   localparam int LW = 16;

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic [N-1:0]         req_valid;
   logic [N-1:0][PW-1:0] req_dst;
   logic [N-1:0][LW-1:0] req_len;
   logic [N-1:0]         d_valid;
   logic [N-1:0]         q_bp;
   logic [N-1:0]         d_bp;
   logic [N-1:0]         grant;
   logic [N-1:0][PW-1:0] sel;
   logic [N-1:0]         sel_valid;
   logic [N-1:0]         q_sof;
   logic [N-1:0]         q_eof;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   routex_xbar_sched #(.NUM_PORTS(N), .PORT_W(PW), .LEN_W(LW)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_VALID (req_valid),
      .REQ_DST   (req_dst),
      .REQ_LEN   (req_len),
      .D_VALID   (d_valid),
      .Q_BP      (q_bp),
      .D_BP      (d_bp),
      .GRANT     (grant),
      .SEL       (sel),
      .SEL_VALID (sel_valid),
      .Q_SOF     (q_sof),
      .Q_EOF     (q_eof)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Packet-level model: which input owns each output, flits left, first-flit flag,
   // and the last input served on each output (the round-robin reference point).
   int m_owner    [N];
   int m_rem      [N];
   bit m_first    [N];
   int m_last_win [N];
   bit m_known = 1'b0;

   function automatic int holder_of(input int i);
      for (int o = 0; o < N; o++) if (m_owner[o] == i) return o;
      return -1;
   endfunction

   always @(negedge CLK) begin : cmp
      logic [N-1:0]         e_grant, e_sv, e_sof, e_eof, e_dbp;
      logic [N-1:0][PW-1:0] e_sel, a_sel;
      int                   c, h;
      if (m_known) begin
         e_grant = '0; e_sv = '0; e_sof = '0; e_eof = '0; e_dbp = '0;
         e_sel = '0; a_sel = '0;
         for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
               e_sv[o]             = 1'b1;
               e_grant[m_owner[o]] = 1'b1;
               e_sel[o]            = PW'(m_owner[o]);
               a_sel[o]            = sel[o];
               if (RST_N && d_valid[m_owner[o]] && !q_bp[o]) begin
                  e_sof[o] = m_first[o];
                  e_eof[o] = (m_rem[o] == 1);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            h = holder_of(i);
            e_dbp[i] = !RST_N || (h < 0) || q_bp[h];
         end
         check("model_grant",     32'(grant),     32'(e_grant));
         check("model_sel_valid", 32'(sel_valid), 32'(e_sv));
         check("model_sel",       32'(a_sel),     32'(e_sel));
         check("model_sof",       32'(q_sof),     32'(e_sof));
         check("model_eof",       32'(q_eof),     32'(e_eof));
         check("model_d_bp",      32'(d_bp),      32'(e_dbp));
      end

      // Advance the model across the coming rising edge.
      if (!RST_N) begin
         for (int o = 0; o < N; o++) begin
            m_owner[o] = -1; m_rem[o] = 0; m_first[o] = 1'b0; m_last_win[o] = N - 1;
         end
         m_known = 1'b1;
      end else if (m_known) begin
         for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
               if (d_valid[m_owner[o]] && !q_bp[o]) begin
                  m_first[o] = 1'b0;
                  if (m_rem[o] == 1) begin
                     m_last_win[o] = m_owner[o];
                     m_owner[o]    = -1;
                     m_rem[o]      = 0;
                  end else begin
                     m_rem[o] = m_rem[o] - 1;
                  end
               end
            end else begin
               for (int k = 1; k <= N; k++) begin
                  c = (m_last_win[o] + k) % N;
                  if (m_owner[o] < 0 && req_valid[c] && !e_grant[c] && int'(req_dst[c]) == o) begin
                     m_owner[o] = c;
                     m_rem[o]   = (req_len[c] == '0) ? 1 : int'(req_len[c]);
                     m_first[o] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         req_valid = '0; q_bp = '0; d_valid = 4'b1111;
         sample();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within the time bound");
      $fatal(1, "timeout");
   end

   initial begin
      req_valid = '0; req_dst = '0; req_len = '0; d_valid = '0; q_bp = '0;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;
      sample();
      check("rst_grant",     32'(grant),     32'h0);
      check("rst_sel_valid", 32'(sel_valid), 32'h0);
      check("rst_sel",       32'(sel),       32'h0);
      check("rst_d_bp",      32'(d_bp),      32'hF);

      // Single 3-flit packet, input 0 -> output 2.
      step();
      d_valid = 4'b1111; req_valid[0] = 1'b1; req_dst[0] = 2'd2; req_len[0] = 16'd3;
      sample();
      check("t1_c0_grant", 32'(grant), 32'h0);
      for (int c = 1; c <= 4; c++) begin
         step();
         req_valid &= ~grant;
         sample();
         if (c == 1) begin
            check("t1_grant",     32'(grant),     32'h1);
            check("t1_sel2",      32'(sel[2]),    32'h0);
            check("t1_sel_valid", 32'(sel_valid), 32'h4);
            check("t1_sof",       32'(q_sof),     32'h4);
            check("t1_no_eof",    32'(q_eof),     32'h0);
         end
         if (c == 3) check("t1_eof", 32'(q_eof), 32'h4);
         if (c == 4) begin
            check("t1_release_grant", 32'(grant),     32'h0);
            check("t1_release_sv",    32'(sel_valid), 32'h0);
         end
      end
      idle_cycles(2);

      // Round-robin: all inputs want output 1, 2 flits each.
      step();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1; req_dst[i] = 2'd1; req_len[i] = 16'd2;
      end
      sample();
      for (int c = 1; c <= 16; c++) begin
         step();
         req_valid &= ~grant;
         if (c == 12) begin
            req_valid[0] = 1'b1; req_valid[3] = 1'b1;
         end
         sample();
         if (c == 1 || c == 4 || c == 7 || c == 10) begin
            check("t2_grant_order", 32'(grant),  32'(1 << ((c - 1) / 3)));
            check("t2_sel1",        32'(sel[1]), 32'((c - 1) / 3));
         end
         if (c == 3) check("t2_idle_gap", 32'(grant), 32'h0);
         if (c == 13) begin
            check("t2_rerequest_grant", 32'(grant),  32'h1);
            check("t2_rerequest_sel",   32'(sel[1]), 32'h0);
         end
         if (c == 16) check("t2_then_input3", 32'(grant), 32'h8);
      end
      idle_cycles(4);

      // Permutation: input i -> output 3-i, 4 flits each.
      step();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1; req_dst[i] = PW'(3 - i); req_len[i] = 16'd4;
      end
      sample();
      for (int c = 1; c <= 5; c++) begin
         step();
         req_valid &= ~grant;
         sample();
         if (c == 1) begin
            check("t3_grant",     32'(grant),     32'hF);
            check("t3_sel_valid", 32'(sel_valid), 32'hF);
            check("t3_sel",       32'(sel),       32'h1B);
            check("t3_sof",       32'(q_sof),     32'hF);
         end
         if (c == 4) check("t3_eof", 32'(q_eof), 32'hF);
         if (c == 5) check("t3_release", 32'(grant), 32'h0);
      end
      idle_cycles(2);

      // Stalls: 5 flits input 1 -> output 0, two Q_BP cycles then one D_VALID gap.
      step();
      req_valid[1] = 1'b1; req_dst[1] = 2'd0; req_len[1] = 16'd5;
      sample();
      for (int c = 1; c <= 9; c++) begin
         step();
         req_valid &= ~grant;
         q_bp    = (c == 3 || c == 4) ? 4'b0001 : 4'b0000;
         d_valid = (c == 6) ? 4'b1101 : 4'b1111;
         sample();
         if (c == 1) check("t4_sof", 32'(q_sof), 32'h1);
         if (c == 2) check("t4_dbp_flowing", 32'(d_bp[1]), 32'h0);
         if (c == 3 || c == 4) begin
            check("t4_dbp_stalled", 32'(d_bp[1]), 32'h1);
            check("t4_stall_no_eof", 32'(q_eof), 32'h0);
         end
         if (c == 5 || c == 7) check("t4_early_eof", 32'(q_eof), 32'h0);
         if (c == 6) check("t4_dvalid_gap_sof", 32'(q_sof), 32'h0);
         if (c == 8) check("t4_eof", 32'(q_eof), 32'h1);
         if (c == 9) check("t4_release", 32'(grant), 32'h0);
      end
      idle_cycles(2);

      // Length 0 and length 1 packets.
      step();
      req_valid[2] = 1'b1; req_dst[2] = 2'd3; req_len[2] = 16'd0;
      req_valid[3] = 1'b1; req_dst[3] = 2'd2; req_len[3] = 16'd1;
      sample();
      step(); req_valid &= ~grant; sample();
      check("t5_sof", 32'(q_sof), 32'hC);
      check("t5_eof", 32'(q_eof), 32'hC);
      step(); sample();
      check("t5_release", 32'(grant), 32'h0);
      check("t5_single_flit", 32'(q_sof | q_eof), 32'h0);
      idle_cycles(2);

      // Reset mid-packet; a 1-flit packet from input 1 first moves output 1's pointer.
      step(); req_valid[1] = 1'b1; req_dst[1] = 2'd1; req_len[1] = 16'd1; sample();
      step(); req_valid &= ~grant; sample();
      check("t6_short_eof", 32'(q_eof), 32'h2);
      step(); req_valid[2] = 1'b1; req_dst[2] = 2'd1; req_len[2] = 16'd8; sample();
      step(); req_valid &= ~grant; sample();
      check("t6_long_sel", 32'(sel[1]), 32'h2);
      step(); RST_N = 1'b0; sample();
      check("t6_rst_sof",  32'(q_sof), 32'h0);
      check("t6_rst_eof",  32'(q_eof), 32'h0);
      check("t6_rst_d_bp", 32'(d_bp),  32'hF);
      step();
      RST_N = 1'b1;
      req_valid[0] = 1'b1; req_dst[0] = 2'd1; req_len[0] = 16'd2;
      req_valid[2] = 1'b1; req_dst[2] = 2'd1; req_len[2] = 16'd2;
      sample();
      check("t6_after_grant", 32'(grant),     32'h0);
      check("t6_after_sv",    32'(sel_valid), 32'h0);
      check("t6_after_d_bp",  32'(d_bp),      32'hF);
      check("t6_after_eof",   32'(q_eof),     32'h0);
      step(); req_valid &= ~grant; sample();
      check("t6_priority_grant", 32'(grant),  32'h1);
      check("t6_priority_sel",   32'(sel[1]), 32'h0);
      idle_cycles(4);

      // Randomized traffic; the model compare runs every cycle.
      for (int n = 0; n < 3000; n++) begin
         step();
         RST_N = ($urandom_range(499) != 0);
         for (int i = 0; i < N; i++) begin
            if (grant[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(2) == 0);
               req_dst[i]   = PW'($urandom_range(N - 1));
               req_len[i]   = LW'($urandom_range(6));
            end
            d_valid[i] = ($urandom_range(4) != 0);
            q_bp[i]    = ($urandom_range(4) == 0);
         end
         sample();
      end
      idle_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
